// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared constants for the MIPS register file and its
// scoreboard. Polarity constants keep the enable comparisons readable.
// The default widths match a 32 x 32-bit MIPS GPR file.
package reg_file_sb_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [RegBus-1:0] ZeroWord = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: one pending bit per register, for long-latency ops.
//   clk, rst          clock, async active-high reset
//   issue_en/addr     long-latency op issued; marks the destination pending
//   lw_en/addr        long-latency result returning; clears its pending bit
//   flush             clears every pending bit
//   rd_en/rd_addr     per-port read enables and packed read addresses
//   rd_busy           per-port RAW stall
//   issue_busy        issue destination already pending (WAW stall)
//   pend_any          OR of all pending bits
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int ADDR_W   = RegAddrBus,
  parameter int RD_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_en,
  input  logic [ADDR_W-1:0]            issue_addr,
  input  logic                         lw_en,
  input  logic [ADDR_W-1:0]            lw_addr,
  input  logic                         flush,
  input  logic [RD_PORTS-1:0]          rd_en,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS-1:0]          rd_busy,
  output logic                         issue_busy,
  output logic                         pend_any
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pend_q, pend_d;

  // Issue is applied after the return so it wins on the same address;
  // flush overrides both.
  always_comb begin
    pend_d = pend_q;
    if (flush) begin
      pend_d = '0;
    end else begin
      if (lw_en == WriteEnable) pend_d[lw_addr] = 1'b0;
      if (issue_en)             pend_d[issue_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) pend_q <= '0;
    else                  pend_q <= pend_d;
  end

  // A result returning this cycle releases its readers immediately,
  // matching the read bypass in the data path.
  genvar i;
  generate
    for (i = 0; i < RD_PORTS; i++) begin : g_busy
      logic [ADDR_W-1:0] ra;
      assign ra = rd_addr[i*ADDR_W +: ADDR_W];
      assign rd_busy[i] = (rd_en[i] == ReadEnable) && (ra != '0) && pend_q[ra] &&
                          !((lw_en == WriteEnable) && (lw_addr == ra));
    end
  endgenerate

  assign issue_busy = (issue_addr != '0) && pend_q[issue_addr] &&
                      !((lw_en == WriteEnable) && (lw_addr == issue_addr));

  assign pend_any = |pend_q;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: MIPS GPR file with N combinational read ports, a pipeline
// write-back port, a long-latency result port and an integrated scoreboard.
//   clk, rst               clock, async active-high reset
//   wb_en/addr/data        pipeline write-back (younger, wins over lw)
//   lw_en/addr/data        long-latency result return
//   issue_en/addr          long-latency issue; issue_busy flags WAW
//   flush                  clear all pending bits
//   rd_en/rd_addr          per-port enables, packed addresses
//   rd_data/rd_busy        per-port packed data and RAW stall
//   pend_any               any register pending
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W   = RegBus,
  parameter int ADDR_W   = RegAddrBus,
  parameter int RD_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_en,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic [DATA_W-1:0]            wb_data,
  input  logic                         lw_en,
  input  logic [ADDR_W-1:0]            lw_addr,
  input  logic [DATA_W-1:0]            lw_data,
  input  logic                         issue_en,
  input  logic [ADDR_W-1:0]            issue_addr,
  output logic                         issue_busy,
  input  logic                         flush,
  input  logic [RD_PORTS-1:0]          rd_en,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_busy,
  output logic                         pend_any
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] ZERO = DATA_W'(ZeroWord);

  logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;

  // wb is applied last so it overwrites lw on an address collision.
  always_comb begin
    regs_d = regs_q;
    if (lw_en == WriteEnable) regs_d[lw_addr] = lw_data;
    if (wb_en == WriteEnable) regs_d[wb_addr] = wb_data;
    regs_d[0] = ZERO;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) regs_q <= '0;
    else                  regs_q <= regs_d;
  end

  genvar i;
  generate
    for (i = 0; i < RD_PORTS; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rdat;
      assign ra = rd_addr[i*ADDR_W +: ADDR_W];

      always_comb begin
        rdat = ZERO;
        if (rst == RstEnable)                              rdat = ZERO;
        else if (ra == '0)                                 rdat = ZERO;
        else if (rd_en[i] != ReadEnable)                   rdat = ZERO;
        else if ((wb_en == WriteEnable) && (wb_addr == ra)) rdat = wb_data;
        else if ((lw_en == WriteEnable) && (lw_addr == ra)) rdat = lw_data;
        else                                               rdat = regs_q[ra];
      end

      assign rd_data[i*DATA_W +: DATA_W] = rdat;
    end
  endgenerate

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .RD_PORTS (RD_PORTS)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .lw_en      (lw_en),
    .lw_addr    (lw_addr),
    .flush      (flush),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_busy    (rd_busy),
    .issue_busy (issue_busy),
    .pend_any   (pend_any)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst;
  logic wb_en, lw_en, issue_en, flush;
  logic [AW-1:0] wb_addr, lw_addr, issue_addr;
  logic [DW-1:0] wb_data, lw_data;
  logic issue_busy, pend_any;
  logic [NP-1:0] rd_en, rd_busy;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(NP)) dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .lw_en(lw_en), .lw_addr(lw_addr), .lw_data(lw_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .issue_busy(issue_busy),
    .flush(flush), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .pend_any(pend_any)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wb_en = 0; lw_en = 0; issue_en = 0; flush = 0;
    wb_addr = '0; lw_addr = '0; issue_addr = '0;
    wb_data = '0; lw_data = '0;
  endtask

  task automatic set_rd(input int p, input int a, input logic en);
    rd_addr[p*AW +: AW] = AW'(a);
    rd_en[p] = en;
  endtask

  function automatic logic [DW-1:0] rdd(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  // advance one edge and settle 1ns past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rd_en = '0;
    rd_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();

    // reset state: every address, every port
    for (int a = 0; a < 16; a++) begin
      for (int p = 0; p < NP; p++) set_rd(p, a, 1'b1);
      #1;
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("rst_data_a%0d_p%0d", a, p), rdd(p), '0);
        chk($sformatf("rst_busy_a%0d_p%0d", a, p), DW'(rd_busy[p]), '0);
      end
    end
    chk("rst_pend_any", DW'(pend_any), '0);

    // wb r5, read next cycle
    wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
    step();
    idle();
    set_rd(0, 5, 1'b1);
    #1;
    chk("wb_r5", rdd(0), 32'hDEADBEEF);
    set_rd(0, 5, 1'b0);
    #1;
    chk("rd_en_low", rdd(0), '0);

    // r0 never written, never busy
    wb_en = 1; wb_addr = 0; wb_data = 32'h1234;
    lw_en = 1; lw_addr = 0; lw_data = 32'h1234;
    issue_en = 1; issue_addr = 0;
    set_rd(0, 0, 1'b1);
    #1;
    chk("r0_bypass", rdd(0), '0);
    step();
    idle();
    #1;
    chk("r0_stored", rdd(0), '0);
    chk("r0_busy", DW'(rd_busy[0]), '0);
    chk("r0_pend_any", DW'(pend_any), '0);
    chk("r0_issue_busy", DW'(issue_busy), '0);

    // same-cycle wb bypass
    wb_en = 1; wb_addr = 7; wb_data = 32'hA;
    set_rd(1, 7, 1'b1);
    #1;
    chk("bypass_r7", rdd(1), 32'hA);
    step();
    idle();

    // issue r9, busy from next cycle, result three cycles later
    issue_en = 1; issue_addr = 9;
    set_rd(0, 9, 1'b1);
    #1;
    chk("r9_busy_same_cycle", DW'(rd_busy[0]), '0);
    step();
    idle();
    issue_addr = 9;
    #1;
    chk("r9_busy_n1", DW'(rd_busy[0]), 1);
    chk("r9_pend_any", DW'(pend_any), 1);
    chk("r9_issue_busy", DW'(issue_busy), 1);
    step();
    chk("r9_busy_n2", DW'(rd_busy[0]), 1);
    step();
    chk("r9_busy_n3", DW'(rd_busy[0]), 1);
    lw_en = 1; lw_addr = 9; lw_data = 32'h55;
    #1;
    chk("r9_ret_busy", DW'(rd_busy[0]), '0);
    chk("r9_ret_data", rdd(0), 32'h55);
    chk("r9_ret_issue_busy", DW'(issue_busy), '0);
    step();
    idle();
    #1;
    chk("r9_after_busy", DW'(rd_busy[0]), '0);
    chk("r9_after_data", rdd(0), 32'h55);
    chk("r9_after_pend_any", DW'(pend_any), '0);

    // wb and lw to same address: wb wins
    wb_en = 1; wb_addr = 3; wb_data = 32'h11;
    lw_en = 1; lw_addr = 3; lw_data = 32'h22;
    set_rd(0, 3, 1'b1);
    #1;
    chk("r3_bypass_wb_wins", rdd(0), 32'h11);
    step();
    idle();
    #1;
    chk("r3_stored", rdd(0), 32'h11);

    // issue and return to r4 in the same cycle: stays pending
    issue_en = 1; issue_addr = 4;
    lw_en = 1; lw_addr = 4; lw_data = 32'h44;
    step();
    idle();
    set_rd(0, 4, 1'b1);
    #1;
    chk("r4_still_busy", DW'(rd_busy[0]), 1);
    chk("r4_data", rdd(0), 32'h44);

    // flush wins over a simultaneous issue
    issue_en = 1; issue_addr = 2;
    step();
    issue_addr = 6;
    step();
    idle();
    set_rd(0, 2, 1'b1); set_rd(1, 6, 1'b1); set_rd(2, 8, 1'b1); set_rd(3, 4, 1'b1);
    #1;
    chk("pre_flush_busy", DW'(rd_busy), 32'b1011);
    flush = 1; issue_en = 1; issue_addr = 8;
    step();
    idle();
    #1;
    chk("flush_busy", DW'(rd_busy), '0);
    chk("flush_pend_any", DW'(pend_any), '0);

    // async reset mid-cycle
    issue_en = 1; issue_addr = 10;
    step();
    idle();
    set_rd(0, 5, 1'b1); set_rd(1, 10, 1'b1);
    #1;
    chk("pre_rst_data", rdd(0), 32'hDEADBEEF);
    chk("pre_rst_busy", DW'(rd_busy[1]), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_data", rdd(0), '0);
    chk("async_rst_busy", DW'(rd_busy), '0);
    chk("async_rst_pend_any", DW'(pend_any), '0);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_r5", rdd(0), '0);
    chk("post_rst_r10_busy", DW'(rd_busy[1]), '0);
    // late result after reset: plain write
    lw_en = 1; lw_addr = 10; lw_data = 32'h77;
    step();
    idle();
    #1;
    chk("late_lw_r10", rdd(1), 32'h77);
    chk("late_lw_pend_any", DW'(pend_any), '0);

    // four ports concurrently: stored, busy, wb bypass, lw bypass
    wb_en = 1; wb_addr = 1; wb_data = 32'h101;
    step();
    idle();
    issue_en = 1; issue_addr = 11;
    step();
    idle();
    wb_en = 1; wb_addr = 12; wb_data = 32'hC0C0;
    lw_en = 1; lw_addr = 13; lw_data = 32'hD0D0;
    set_rd(0, 1, 1'b1); set_rd(1, 11, 1'b1); set_rd(2, 12, 1'b1); set_rd(3, 13, 1'b1);
    #1;
    chk("p0_stored", rdd(0), 32'h101);
    chk("p1_data", rdd(1), '0);
    chk("p2_wb_bypass", rdd(2), 32'hC0C0);
    chk("p3_lw_bypass", rdd(3), 32'hD0D0);
    chk("ports_busy", DW'(rd_busy), 32'b0010);
    step();
    idle();
    #1;
    chk("p2_stored", rdd(2), 32'hC0C0);
    chk("p3_stored", rdd(3), 32'hD0D0);
    chk("p1_still_busy", DW'(rd_busy), 32'b0010);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
